// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter with a word FIFO, runtime baud divisor, parity and stop-bit format
module uart_tx_fifo_param #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          i_tx_valid,
  input  logic [DATA_W-1:0]             i_tx_data,
  output logic                          o_tx_ready,
  input  logic [DIV_W-1:0]              i_clks_per_bit,
  input  logic                          i_parity_en,
  input  logic                          i_parity_odd,
  input  logic                          i_two_stop,
  output logic                          o_tx_serial,
  output logic                          o_tx_active,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  state_t st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic pe_q, pe_d, par_q, par_d, ts_q, ts_d;
  logic ser_q, ser_d, act_q, act_d, done_q, done_d;
  logic push, pop, tick, last;
  assign o_tx_ready = !lvl_q[AW];
  assign push = i_tx_valid && o_tx_ready;
  assign tick = cnt_q == div_q - DIV_W'(1);
  assign last = tick && st_q == STOP && bit_q[0] == ts_q;
  assign pop = lvl_q != '0 && (st_q == IDLE || last);
  assign o_tx_serial = ser_q;
  assign o_tx_active = act_q;
  assign o_tx_done = done_q;
  assign o_fifo_level = lvl_q;
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    lvl_d = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    st_d = st_q;
    cnt_d = (st_q == IDLE || tick) ? '0 : cnt_q + DIV_W'(1);
    bit_d = bit_q;
    dat_d = dat_q;
    div_d = div_q;
    pe_d = pe_q;
    par_d = par_q;
    ts_d = ts_q;
    ser_d = ser_q;
    done_d = 1'b0;
    if (tick)
      case (st_q)
        START: begin
          st_d = DATA;
          bit_d = '0;
          ser_d = dat_q[0];
        end
        DATA: begin
          if (bit_q == 4'(DATA_W - 1)) begin
            st_d = pe_q ? PARITY : STOP;
            bit_d = '0;
            ser_d = pe_q ? par_q : 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            dat_d = dat_q >> 1;
            ser_d = dat_q[1];
          end
        end
        PARITY: begin
          st_d = STOP;
          bit_d = '0;
          ser_d = 1'b1;
        end
        STOP: begin
          if (bit_q[0] == ts_q) begin
            st_d = IDLE;
            done_d = 1'b1;
          end else bit_d = 4'd1;
        end
        default: ;
      endcase
    if (pop) begin
      st_d = START;
      cnt_d = '0;
      bit_d = '0;
      ser_d = 1'b0;
      dat_d = mem_q[rd_q];
      div_d = i_clks_per_bit < DIV_W'(2) ? DIV_W'(2) : i_clks_per_bit;
      pe_d = i_parity_en;
      par_d = ^mem_q[rd_q] ^ i_parity_odd;
      ts_d = i_two_stop;
    end
    act_d = st_d != IDLE;
  end
  always_ff @(posedge wb_clk_i)
    if (push) mem_q[wr_q] <= i_tx_data;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      st_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      dat_q <= '0;
      div_q <= DIV_W'(2);
      pe_q <= 1'b0;
      par_q <= 1'b0;
      ts_q <= 1'b0;
      ser_q <= 1'b1;
      act_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      dat_q <= dat_d;
      div_q <= div_d;
      pe_q <= pe_d;
      par_q <= par_d;
      ts_q <= ts_d;
      ser_q <= ser_d;
      act_q <= act_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: scoreboard bench decoding serial frames against pushed words and frame config
module tb_uart_tx_fifo_param;
  logic clk = 0, rst = 1, valid = 0, pe = 0, po = 0, ts = 0;
  logic [7:0] data = 0;
  logic [15:0] cps = 16'd4;
  logic ready, ser, active, done;
  logic [2:0] level;
  int total = 0, bad = 0, nfr = 0, b2b = 0, n0, g0;
  bit busy = 0;
  typedef struct {logic [7:0] d; int div; bit pe, po, ts;} ent_t;
  ent_t q[$];
  uart_tx_fifo_param dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .i_tx_valid(valid), .i_tx_data(data), .o_tx_ready(ready),
    .i_clks_per_bit(cps), .i_parity_en(pe), .i_parity_odd(po), .i_two_stop(ts),
    .o_tx_serial(ser), .o_tx_active(active), .o_tx_done(done), .o_fifo_level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] frame_of(input ent_t e);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = e.d[i];
    k = 9;
    if (e.pe) begin
      f[k] = ^e.d ^ e.po;
      k++;
    end
    f[k] = 1'b1;
    return f;
  endfunction
  task automatic drive(input logic [7:0] d);
    @(negedge clk);
    valid = 1;
    data = d;
    if (ready) q.push_back('{d: d, div: (cps < 2) ? 2 : int'(cps), pe: pe, po: po, ts: ts});
  endtask
  task automatic stop_drive;
    @(negedge clk);
    valid = 0;
  endtask
  task automatic wait_idle;
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((q.size() != 0 || busy || active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
    @(negedge clk);
  endtask
  initial begin : mon
    bit have, ab, st, first;
    ent_t e;
    logic [15:0] ef, gf;
    logic v;
    int nb, dn, na;
    have = 0;
    forever begin
      if (!have) @(negedge clk);
      have = 0;
      if (!rst && ser === 1'b0) begin
        busy = 1;
        chk("frame_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          ef = frame_of(e);
          nb = 10 + int'(e.pe) + int'(e.ts);
          gf = '1;
          ab = 0;
          first = 1;
          dn = 0;
          na = 0;
          for (int b = 0; b < nb; b++) begin
            st = 1;
            for (int c = 0; c < e.div; c++) begin
              if (!first) @(negedge clk);
              first = 0;
              if (rst) ab = 1;
              if (ab) break;
              if (c == 0) v = ser;
              else if (ser !== v) st = 0;
              if (b != 0 || c != 0) dn += int'(done);
              na += int'(active !== 1'b1);
            end
            if (ab) break;
            gf[b] = st ? v : ~ef[b];
          end
          if (!ab) begin
            chk("frame_bits", gf, ef);
            chk("done_in_frame", dn, 0);
            chk("active_in_frame", na, 0);
            @(negedge clk);
            if (!rst) begin
              chk("done_end", done, 1);
              chk("active_end", active, !ser);
              if (ser === 1'b0) b2b++;
              nfr++;
              have = 1;
            end
          end
        end else while (!rst && ser === 1'b0) @(negedge clk);
        busy = 0;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_serial", ser, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", ready, 1);
    rst = 0;
    drive(8'hA5);
    stop_drive();
    wait_idle();
    chk("t1_idle_serial", ser, 1);
    pe = 1;
    drive(8'h03);
    stop_drive();
    wait_idle();
    po = 1;
    drive(8'h03);
    stop_drive();
    wait_idle();
    ts = 1;
    drive(8'h03);
    stop_drive();
    wait_idle();
    pe = 0;
    po = 0;
    ts = 0;
    n0 = nfr;
    g0 = b2b;
    for (int i = 0; i < 6; i++) begin
      drive(8'(8'h10 + i));
      if (i == 5) begin
        chk("t3_ready_full", ready, 0);
        chk("t3_level_full", level, 4);
      end
    end
    stop_drive();
    wait_idle();
    chk("t3_frames", nfr - n0, 5);
    chk("t3_back_to_back", b2b - g0, 4);
    g0 = b2b;
    drive(8'h3C);
    stop_drive();
    repeat (10) @(negedge clk);
    cps = 16'd8;
    drive(8'hC3);
    stop_drive();
    wait_idle();
    chk("t4_back_to_back", b2b - g0, 1);
    cps = 16'd4;
    n0 = nfr;
    drive(8'h01);
    drive(8'h02);
    drive(8'h03);
    stop_drive();
    repeat (12) @(negedge clk);
    chk("t5_active_before", active, 1);
    #2 rst = 1;
    #1;
    chk("t5_serial", ser, 1);
    chk("t5_active", active, 0);
    chk("t5_done", done, 0);
    chk("t5_level", level, 0);
    chk("t5_ready", ready, 1);
    repeat (2) @(negedge clk);
    rst = 0;
    q.delete();
    repeat (200) begin
      @(negedge clk);
      if (ser !== 1'b1 || done !== 1'b0) break;
    end
    chk("t5_no_frames", nfr, n0);
    chk("t5_idle_serial", ser, 1);
    chk("t5_idle_level", level, 0);
    cps = 16'd0;
    drive(8'h5A);
    drive(8'h96);
    stop_drive();
    chk("t6_simul_level", level, 1);
    wait_idle();
    cps = 16'd1;
    drive(8'h0F);
    stop_drive();
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
